// File: rtl/bsg_skid_bypass_rx_if.sv
// Ready/valid link bundle for bsg_skid_bypass_rx.
// master: producer/consumer side (drives v_i, data_i, yumi_i).
// slave: the buffer itself.
interface bsg_skid_bypass_rx_if #(
  parameter int unsigned width_p = 16
);
  logic               v_i;
  logic [width_p-1:0] data_i;
  logic               ready_o;
  logic               v_o;
  logic [width_p-1:0] data_o;
  logic               yumi_i;
  logic [1:0]         count_o;

  modport master (
    output v_i, data_i, yumi_i,
    input  ready_o, v_o, data_o, count_o
  );

  modport slave (
    input  v_i, data_i, yumi_i,
    output ready_o, v_o, data_o, count_o
  );
endinterface

// File: rtl/bsg_skid_bypass_rx.sv
// Two-entry receive-side holding buffer, FIFO order, registered ready_o.
// Build option: define BSG_SKID_RX_BYPASS_EN to let a word arriving into an
// empty buffer pass straight through to the output in the same cycle.
// Without it, every word is registered first (one cycle latency).
module bsg_skid_bypass_rx #(
  parameter int unsigned width_p = 16
) (
  input  logic                clk_i,
  input  logic                reset_n_i,
  bsg_skid_bypass_rx_if.slave bus
);

  typedef enum logic [1:0] {StEmpty, StOne, StTwo} state_e;

  state_e             r_state, w_state_d;
  logic [width_p-1:0] r_slot0, r_slot1;
  logic [width_p-1:0] w_slot0_d, w_slot1_d;
  logic               r_ready, w_ready_d;
  logic               w_accept, w_take, w_v_o;

  assign w_accept = bus.v_i & r_ready;
  // A yumi without a valid word changes nothing.
  assign w_take   = bus.yumi_i & w_v_o;

  // State register; r_ready doubles as the out-of-reset flag.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_state <= StEmpty;
      r_ready <= 1'b0;
    end else begin
      r_state <= w_state_d;
      r_ready <= w_ready_d;
    end
  end

  // Storage slots: slot0 is the head, slot1 the tail.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_slot0 <= '0;
      r_slot1 <= '0;
    end else begin
      r_slot0 <= w_slot0_d;
      r_slot1 <= w_slot1_d;
    end
  end

  // Next state and slot updates.
  always_comb begin
    w_state_d = r_state;
    w_slot0_d = r_slot0;
    w_slot1_d = r_slot1;
    case (r_state)
      StEmpty: begin
        if (w_accept) begin
`ifdef BSG_SKID_RX_BYPASS_EN
          // Taken in the same cycle means the word passed through unstored.
          if (!w_take) begin
            w_state_d = StOne;
            w_slot0_d = bus.data_i;
          end
`else
          w_state_d = StOne;
          w_slot0_d = bus.data_i;
`endif
        end
      end
      StOne: begin
        if (w_accept && w_take) begin
          w_slot0_d = bus.data_i;
        end else if (w_accept) begin
          w_state_d = StTwo;
          w_slot1_d = bus.data_i;
        end else if (w_take) begin
          w_state_d = StEmpty;
        end
      end
      StTwo: begin
        // ready_o is low here, so only the consumer side can move.
        if (w_take) begin
          w_state_d = StOne;
          w_slot0_d = r_slot1;
        end
      end
      default: w_state_d = StEmpty;
    endcase
    // Ready is computed from the next state so it is registered yet never late.
    w_ready_d = (w_state_d != StTwo);
  end

  // Outputs decoded from the current state.
  always_comb begin
    w_v_o       = 1'b0;
    bus.data_o  = r_slot0;
    bus.count_o = 2'd0;
    case (r_state)
      StEmpty: begin
`ifdef BSG_SKID_RX_BYPASS_EN
        // Gate with r_ready so nothing shows valid before a transfer is possible.
        w_v_o      = bus.v_i & r_ready;
        bus.data_o = r_ready ? bus.data_i : '0;
`endif
      end
      StOne: begin
        w_v_o       = 1'b1;
        bus.count_o = 2'd1;
      end
      StTwo: begin
        w_v_o       = 1'b1;
        bus.count_o = 2'd2;
      end
      default: w_v_o = 1'b0;
    endcase
  end

  assign bus.v_o     = w_v_o;
  assign bus.ready_o = r_ready;

  // Consumer protocol: yumi_i must only be raised while v_o is high.
  assert property (@(posedge clk_i) disable iff (!reset_n_i) !(bus.yumi_i && !w_v_o));

endmodule
